key_schedule_ctrl: RTL and testbench

- Iterative AES key-schedule controller. Generates one expanded-key word per clock with a single shared sub_word instance, then stores the words in an internal round-key buffer.
- Serves 128-bit round keys by index to the encryption/decryption round cores over a registered read port.
- Replaces the fully unrolled combinational key expansion where area matters. Supports AES-128/192/256 through parameters.

---
 rtl/key_schedule_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_key_schedule_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_ctrl.sv
// Iterative AES key-schedule controller (AES-128/192/256 via NK/NR).
// Produces one expanded-key word per clock through a single shared SubWord
// datapath, keeps the full schedule in an internal buffer, and serves 128-bit
// round keys over a registered read port.
// Optional feature: define KS_ZEROIZE_EN to add the i_zeroize input, which
// wipes the buffer and returns the controller to IDLE.
module key_schedule_ctrl #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
`ifdef KS_ZEROIZE_EN
  input  logic             i_zeroize,
`endif
  input  logic             i_start,
  input  logic [32*NK-1:0] i_cypher_key,
  input  logic             i_rd_req,
  input  logic [3:0]       i_rd_round,
  output logic             o_busy,
  output logic             o_keys_ready,
  output logic             o_rd_valid,
  output logic             o_rd_err,
  output logic [127:0]     o_round_key
);

  localparam int         NW      = 4 * (NR + 1);
  localparam logic [5:0] W_FIRST = 6'(NK);
  localparam logic [5:0] W_LAST  = 6'(NW - 1);
  localparam logic [2:0] PH_LAST = 3'(NK - 1);
  localparam logic [3:0] RD_MAX  = 4'(NR);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t      state;
  logic [5:0]  w;
  logic [2:0]  phase;
  logic [7:0]  rcon;
  logic [31:0] key_buf [NW];

  logic        zeroize;
  logic        start_acc;
  logic        rd_ok;
  logic        in_range;
  logic [5:0]  rd_base;
  logic [127:0] rd_word;

  logic [31:0] prev_word;
  logic [31:0] old_word;
  logic [31:0] rot_word;
  logic [31:0] sw_in;
  logic [31:0] sw_out;
  logic [31:0] t_word;
  logic [31:0] new_word;

`ifdef KS_ZEROIZE_EN
  assign zeroize = i_zeroize;
`else
  assign zeroize = 1'b0;
`endif

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // AES S-box: multiplicative inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = gf_mul(x, x);
    inv = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // A start is taken only outside EXPAND; a read only with a complete schedule
  // and no start competing for the buffer on the same edge.
  always_comb begin
    start_acc = i_start && (state != EXPAND) && !zeroize;
    rd_ok     = i_rd_req && o_keys_ready && !start_acc && !zeroize;
    in_range  = (i_rd_round <= RD_MAX);
    rd_base   = {i_rd_round, 2'b00};
    rd_word   = {key_buf[rd_base + 6'd3], key_buf[rd_base + 6'd2],
                 key_buf[rd_base + 6'd1], key_buf[rd_base]};
  end

  // Next expanded word: phase tracks w mod NK so no divider is needed
  always_comb begin
    prev_word = key_buf[w - 6'd1];
    old_word  = key_buf[w - W_FIRST];
    rot_word  = {prev_word[23:0], prev_word[31:24]};
    sw_in     = (phase == 3'd0) ? rot_word : prev_word;
    sw_out    = sub_word(sw_in);
    if (phase == 3'd0) begin
      t_word = sw_out ^ {rcon, 24'h000000};
    end else if ((NK > 6) && (phase == 3'd4)) begin
      t_word = sw_out;
    end else begin
      t_word = prev_word;
    end
    new_word = old_word ^ t_word;
  end

  // Round-key buffer: key load on start, one expanded word per EXPAND cycle
  always_ff @(posedge i_clk) begin
    if (zeroize) begin
      for (int i = 0; i < NW; i++) key_buf[i] <= 32'h0;
    end else if (start_acc) begin
      for (int j = 0; j < NK; j++) key_buf[j] <= i_cypher_key[32*j +: 32];
    end else if (state == EXPAND) begin
      key_buf[w] <= new_word;
    end
  end

  // Control FSM plus registered status and read-response outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      w            <= 6'd0;
      phase        <= 3'd0;
      rcon         <= 8'h01;
      o_busy       <= 1'b0;
      o_keys_ready <= 1'b0;
      o_rd_valid   <= 1'b0;
      o_rd_err     <= 1'b0;
      o_round_key  <= 128'h0;
    end else if (zeroize) begin
      state        <= IDLE;
      o_busy       <= 1'b0;
      o_keys_ready <= 1'b0;
      o_rd_valid   <= 1'b0;
      o_rd_err     <= 1'b0;
      o_round_key  <= 128'h0;
    end else begin
      o_rd_valid <= rd_ok;
      o_rd_err   <= rd_ok && !in_range;
      if (rd_ok) o_round_key <= in_range ? rd_word : 128'h0;
      case (state)
        IDLE, DONE: begin
          if (start_acc) begin
            w            <= W_FIRST;
            phase        <= 3'd0;
            rcon         <= 8'h01;
            state        <= EXPAND;
            o_busy       <= 1'b1;
            o_keys_ready <= 1'b0;
          end
        end
        EXPAND: begin
          if (phase == 3'd0) rcon <= xtime(rcon);
          phase <= (phase == PH_LAST) ? 3'd0 : phase + 3'd1;
          w     <= w + 6'd1;
          if (w == W_LAST) begin
            state        <= DONE;
            o_busy       <= 1'b0;
            o_keys_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl: one instance each of AES-128,
// AES-192 and AES-256, driven with FIPS-197 directed vectors.
// Zeroize scenario is compiled in when KS_ZEROIZE_EN is defined.
module tb_key_schedule_ctrl;

  localparam logic [127:0] K128    = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
  localparam logic [127:0] R128_1  = 128'h2a6c7605_23a33939_88542cb1_a0fafe17;
  localparam logic [127:0] R128_10 = 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8;
  localparam logic [127:0] Z_R1    = 128'h62636363_62636363_62636363_62636363;
  localparam logic [127:0] Z_R10   = 128'h6f8f188e_23e951cf_3e92e211_b4ef5bcb;
  localparam logic [191:0] K192    = 192'h522c6b7b_62f8ead2_809079e5_c810f32b_da0e6452_8e73b0f7;
  localparam logic [127:0] R192_12 = 128'h01002202_8ecc7204_448c773c_e98ba06f;
  localparam logic [255:0] K256    = 256'h0914dff4_2d9810a3_3b6108d7_1f352c07_857d7781_2b73aef0_15ca71be_603deb10;
  localparam logic [127:0] R256_14 = 128'h706c631e_046df344_e6188d0b_fe4890d1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   start;
  logic [2:0]   rd_req;
  logic [3:0]   rd_round [3];
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;
  logic [2:0]   busy;
  logic [2:0]   ready;
  logic [2:0]   rd_valid;
  logic [2:0]   rd_err;
  logic [127:0] rk [3];
`ifdef KS_ZEROIZE_EN
  logic [2:0]   zero;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_schedule_ctrl #(.NK(4), .NR(10)) u_ks4 (
    .i_clk(clk), .i_rst_n(rst_n),
`ifdef KS_ZEROIZE_EN
    .i_zeroize(zero[0]),
`endif
    .i_start(start[0]), .i_cypher_key(key4), .i_rd_req(rd_req[0]), .i_rd_round(rd_round[0]),
    .o_busy(busy[0]), .o_keys_ready(ready[0]), .o_rd_valid(rd_valid[0]), .o_rd_err(rd_err[0]),
    .o_round_key(rk[0]));

  key_schedule_ctrl #(.NK(6), .NR(12)) u_ks6 (
    .i_clk(clk), .i_rst_n(rst_n),
`ifdef KS_ZEROIZE_EN
    .i_zeroize(zero[1]),
`endif
    .i_start(start[1]), .i_cypher_key(key6), .i_rd_req(rd_req[1]), .i_rd_round(rd_round[1]),
    .o_busy(busy[1]), .o_keys_ready(ready[1]), .o_rd_valid(rd_valid[1]), .o_rd_err(rd_err[1]),
    .o_round_key(rk[1]));

  key_schedule_ctrl #(.NK(8), .NR(14)) u_ks8 (
    .i_clk(clk), .i_rst_n(rst_n),
`ifdef KS_ZEROIZE_EN
    .i_zeroize(zero[2]),
`endif
    .i_start(start[2]), .i_cypher_key(key8), .i_rd_req(rd_req[2]), .i_rd_round(rd_round[2]),
    .o_busy(busy[2]), .o_keys_ready(ready[2]), .o_rd_valid(rd_valid[2]), .o_rd_err(rd_err[2]),
    .o_round_key(rk[2]));

  // Pulse start for one edge (E0); returns at the falling edge after E0
  task automatic do_start(input int idx, input logic [255:0] k);
    @(negedge clk);
    case (idx)
      0:       key4 = k[127:0];
      1:       key6 = k[191:0];
      default: key8 = k;
    endcase
    start[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[idx] = 1'b0;
  endtask

  // Count rising edges after E0 until o_keys_ready is seen, bounded
  task automatic wait_ready(input int idx, output int n);
    n = 0;
    while (ready[idx] !== 1'b1 && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  // One-cycle read request; returns when the response is visible
  task automatic do_read(input int idx, input logic [3:0] r);
    @(negedge clk);
    rd_req[idx]   = 1'b1;
    rd_round[idx] = r;
    @(posedge clk);
    @(negedge clk);
    rd_req[idx] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++; if (busy[i] !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy[%0d]: got %b expected 0", i, busy[i]); end
      checks++; if (ready[i] !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready[%0d]: got %b expected 0", i, ready[i]); end
      checks++; if (rd_valid[i] !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid[%0d]: got %b expected 0", i, rd_valid[i]); end
      checks++; if (rd_err[i] !== 1'b0) begin errors++; $display("[TB] FAIL reset_err[%0d]: got %b expected 0", i, rd_err[i]); end
      checks++; if (rk[i] !== 128'h0) begin errors++; $display("[TB] FAIL reset_key[%0d]: got %h expected 0", i, rk[i]); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_aes128;
    int n;
    do_start(0, 256'(K128));
    wait_ready(0, n);
    checks++; if (n !== 40) begin errors++; $display("[TB] FAIL aes128_latency: got %0d expected 40", n); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("[TB] FAIL aes128_busy_done: got %b expected 0", busy[0]); end
    do_read(0, 4'd10);
    checks++; if (rd_valid[0] !== 1'b1) begin errors++; $display("[TB] FAIL aes128_r10_valid: got %b expected 1", rd_valid[0]); end
    checks++; if (rd_err[0] !== 1'b0) begin errors++; $display("[TB] FAIL aes128_r10_err: got %b expected 0", rd_err[0]); end
    checks++; if (rk[0] !== R128_10) begin errors++; $display("[TB] FAIL aes128_r10_key: got %h expected %h", rk[0], R128_10); end
    do_read(0, 4'd0);
    checks++; if (rk[0] !== K128) begin errors++; $display("[TB] FAIL aes128_r0_key: got %h expected %h", rk[0], K128); end
    do_read(0, 4'd1);
    checks++; if (rk[0] !== R128_1) begin errors++; $display("[TB] FAIL aes128_r1_key: got %h expected %h", rk[0], R128_1); end
    @(negedge clk);
    checks++; if (rd_valid[0] !== 1'b0) begin errors++; $display("[TB] FAIL aes128_valid_pulse: got %b expected 0", rd_valid[0]); end
    checks++; if (rk[0] !== R128_1) begin errors++; $display("[TB] FAIL aes128_key_hold: got %h expected %h", rk[0], R128_1); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    rd_req[0] = 1'b1; rd_round[0] = 4'd0;
    @(posedge clk); @(negedge clk);
    rd_round[0] = 4'd10;
    checks++; if (rd_valid[0] !== 1'b1 || rk[0] !== K128) begin errors++; $display("[TB] FAIL b2b_first: got valid %b key %h expected 1 %h", rd_valid[0], rk[0], K128); end
    @(posedge clk); @(negedge clk);
    rd_round[0] = 4'd11;
    checks++; if (rd_valid[0] !== 1'b1 || rk[0] !== R128_10) begin errors++; $display("[TB] FAIL b2b_second: got valid %b key %h expected 1 %h", rd_valid[0], rk[0], R128_10); end
    @(posedge clk); @(negedge clk);
    rd_req[0] = 1'b0;
    checks++; if (rd_valid[0] !== 1'b1 || rd_err[0] !== 1'b1 || rk[0] !== 128'h0) begin errors++; $display("[TB] FAIL b2b_third: got valid %b err %b key %h expected 1 1 0", rd_valid[0], rd_err[0], rk[0]); end
    @(posedge clk); @(negedge clk);
    checks++; if (rd_valid[0] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: got %b expected 0", rd_valid[0]); end
  endtask

  task automatic test_out_of_range;
    do_read(0, 4'd11);
    checks++; if (rd_valid[0] !== 1'b1) begin errors++; $display("[TB] FAIL oor_valid: got %b expected 1", rd_valid[0]); end
    checks++; if (rd_err[0] !== 1'b1) begin errors++; $display("[TB] FAIL oor_err: got %b expected 1", rd_err[0]); end
    checks++; if (rk[0] !== 128'h0) begin errors++; $display("[TB] FAIL oor_key: got %h expected 0", rk[0]); end
    do_read(0, 4'd10);
    checks++; if (rd_err[0] !== 1'b0 || rk[0] !== R128_10) begin errors++; $display("[TB] FAIL oor_recover: got err %b key %h expected 0 %h", rd_err[0], rk[0], R128_10); end
  endtask

  task automatic test_start_ignored_rekey;
    int n;
    do_start(0, 256'(K128));
    n = 0;
    while (ready[0] !== 1'b1 && n < 200) begin
      if (n == 5) begin rd_req[0] = 1'b1; rd_round[0] = 4'd0; end
      if (n == 10) start[0] = 1'b1;
      @(posedge clk);
      n++;
      @(negedge clk);
      rd_req[0] = 1'b0;
      start[0]  = 1'b0;
      if (n == 6) begin
        checks++; if (rd_valid[0] !== 1'b0) begin errors++; $display("[TB] FAIL early_read_valid: got %b expected 0", rd_valid[0]); end
        checks++; if (busy[0] !== 1'b1) begin errors++; $display("[TB] FAIL expand_busy: got %b expected 1", busy[0]); end
      end
    end
    checks++; if (n !== 40) begin errors++; $display("[TB] FAIL ignored_start_latency: got %0d expected 40", n); end
    do_read(0, 4'd10);
    checks++; if (rk[0] !== R128_10) begin errors++; $display("[TB] FAIL ignored_start_key: got %h expected %h", rk[0], R128_10); end
    do_start(0, 256'h0);
    checks++; if (ready[0] !== 1'b0 || busy[0] !== 1'b1) begin errors++; $display("[TB] FAIL rekey_drop: got ready %b busy %b expected 0 1", ready[0], busy[0]); end
    wait_ready(0, n);
    checks++; if (n !== 40) begin errors++; $display("[TB] FAIL rekey_latency: got %0d expected 40", n); end
    do_read(0, 4'd1);
    checks++; if (rk[0] !== Z_R1) begin errors++; $display("[TB] FAIL rekey_r1: got %h expected %h", rk[0], Z_R1); end
    do_read(0, 4'd10);
    checks++; if (rk[0] !== Z_R10) begin errors++; $display("[TB] FAIL rekey_r10: got %h expected %h", rk[0], Z_R10); end
  endtask

  task automatic test_aes192;
    int n;
    do_start(1, 256'(K192));
    wait_ready(1, n);
    checks++; if (n !== 46) begin errors++; $display("[TB] FAIL aes192_latency: got %0d expected 46", n); end
    do_read(1, 4'd12);
    checks++; if (rd_valid[1] !== 1'b1 || rk[1] !== R192_12) begin errors++; $display("[TB] FAIL aes192_r12: got valid %b key %h expected 1 %h", rd_valid[1], rk[1], R192_12); end
    do_read(1, 4'd13);
    checks++; if (rd_err[1] !== 1'b1 || rk[1] !== 128'h0) begin errors++; $display("[TB] FAIL aes192_r13_err: got err %b key %h expected 1 0", rd_err[1], rk[1]); end
  endtask

  task automatic test_aes256;
    int n;
    do_start(2, K256);
    wait_ready(2, n);
    checks++; if (n !== 52) begin errors++; $display("[TB] FAIL aes256_latency: got %0d expected 52", n); end
    do_read(2, 4'd14);
    checks++; if (rd_valid[2] !== 1'b1 || rk[2] !== R256_14) begin errors++; $display("[TB] FAIL aes256_r14: got valid %b key %h expected 1 %h", rd_valid[2], rk[2], R256_14); end
    do_read(2, 4'd0);
    checks++; if (rk[2] !== K256[127:0]) begin errors++; $display("[TB] FAIL aes256_r0: got %h expected %h", rk[2], K256[127:0]); end
    do_read(2, 4'd15);
    checks++; if (rd_err[2] !== 1'b1) begin errors++; $display("[TB] FAIL aes256_r15_err: got %b expected 1", rd_err[2]); end
  endtask

  task automatic test_reset_mid;
    do_start(0, 256'(K128));
    repeat (19) @(posedge clk);
    @(negedge clk);
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy: got %b expected 1", busy[0]); end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if ({busy[0], ready[0], rd_valid[0], rd_err[0]} !== 4'b0000) begin errors++; $display("[TB] FAIL mid_reset_flags: got %b expected 0000", {busy[0], ready[0], rd_valid[0], rd_err[0]}); end
    checks++; if (rk[0] !== 128'h0) begin errors++; $display("[TB] FAIL mid_reset_key: got %h expected 0", rk[0]); end
    rst_n = 1'b1;
    do_read(0, 4'd0);
    checks++; if (rd_valid[0] !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_read: got %b expected 0", rd_valid[0]); end
  endtask

`ifdef KS_ZEROIZE_EN
  task automatic test_zeroize;
    int n;
    do_start(0, 256'(K128));
    wait_ready(0, n);
    do_read(0, 4'd10);
    @(negedge clk);
    zero[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    zero[0] = 1'b0;
    checks++; if ({busy[0], ready[0], rd_valid[0]} !== 3'b000 || rk[0] !== 128'h0) begin errors++; $display("[TB] FAIL zeroize_state: got flags %b key %h expected 000 0", {busy[0], ready[0], rd_valid[0]}, rk[0]); end
    do_read(0, 4'd10);
    checks++; if (rd_valid[0] !== 1'b0) begin errors++; $display("[TB] FAIL zeroize_read: got %b expected 0", rd_valid[0]); end
    do_start(0, 256'(K128));
    wait_ready(0, n);
    checks++; if (n !== 40) begin errors++; $display("[TB] FAIL zeroize_latency: got %0d expected 40", n); end
    do_read(0, 4'd10);
    checks++; if (rk[0] !== R128_10) begin errors++; $display("[TB] FAIL zeroize_rekey: got %h expected %h", rk[0], R128_10); end
  endtask
`endif

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    start  = 3'b000;
    rd_req = 3'b000;
    for (int i = 0; i < 3; i++) rd_round[i] = 4'd0;
    key4 = '0;
    key6 = '0;
    key8 = '0;
`ifdef KS_ZEROIZE_EN
    zero = 3'b000;
`endif
    test_reset;
    test_aes128;
    test_back_to_back;
    test_out_of_range;
    test_start_ignored_rekey;
    test_aes192;
    test_aes256;
    test_reset_mid;
`ifdef KS_ZEROIZE_EN
    test_zeroize;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
